uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive front end of the UART: synchronises the raw rx pin, detects start bits, oversamples each bit, checks parity and stop bits, and presents each received word on a valid/ready interface.
- Sits directly upstream of the uart receive buffer, which consumes words via valid/ready.
- Frame format is compile-time configured to match the uart block: data width, stop bits, parity mode, baud rate.

Parameters:
- CLK_, 50000000, system clock frequency in Hz.
- BAUD_, 115200, line baud rate.
- DATA_, 8, data bits per frame (5..9).
- STOP_, 1, stop bits per frame (1 or 2).
- PARITY, "none", parity mode: "none", "even", "odd", "mark" or "space".
- OVERSAMPLE_, 16, oversample ticks per bit (even, >=8).

Ports:
- clk  input  1  system clock.
- rst_  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- data  output  DATA_  received word, LSB first on the line.
- valid  output  1  data and flags hold a word.
- ready  input  1  consumer accepts the word when valid && ready.
- parity_err  output  1  parity mismatch for the held word; qualified by valid.
- frame_err  output  1  a stop bit sampled 0 for the held word; qualified by valid.
- overrun  output  1  one-cycle pulse when a completed word was dropped.
- busy  output  1  frame reception in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock (clk). Reset rst_ is asynchronous and active-low.
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, rx synchroniser flops=1, state=IDLE, all counters=0.
- Reset mid-frame: the frame is abandoned. There is no partial output after release.
- Input synchronisation: rx passes through a 2-flop synchroniser. All logic uses the synchronised value (rxs).
- Tick generator: a free-running divider of round(CLK_/(BAUD_*OVERSAMPLE_)) clocks, minimum 1. It emits a one-clk tick and wraps to 0. The divider restarts at 0 on the falling edge that starts a frame.
- Sample counter: sc counts ticks 0..OVERSAMPLE_-1 within each bit.
- Bit value: majority of rxs at ticks M-1, M and M+1, where M=OVERSAMPLE_/2. The decision is taken at tick M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on a rxs 1->0 transition go to START with sc=0.
- START: at the decision tick, bit=1 means glitch: return to IDLE with no output. Otherwise continue; at sc wrap go to DATA.
- DATA: shift the decided bit into the shift register LSB first. After DATA_ bits go to PARITY, or to STOP if PARITY="none".
- PARITY check: the expected bit is:
  - "even": XOR of the data bits.
  - "odd": the inverse of that XOR.
  - "mark": 1.
  - "space": 0.
  A mismatch sets an internal perr.
- STOP: each of the STOP_ stop bits is decided. Any 0 sets an internal ferr.
- Word completion: at the decision tick of the last stop bit the word completes. This is the completion point; the FSM does not wait out the full stop bit.
  - Without ferr: the next state is IDLE.
  - With ferr: the next state is WAIT_IDLE, which waits for rxs=1 before entering IDLE. A held break therefore yields exactly one word.
- Output latency: valid, data and the flags update on the clk following the completion point.
- Output register: holds data, parity_err and frame_err with valid=1 until the cycle in which valid && ready. On that cycle valid clears the next clk unless a new word completes in the same cycle; the new word then loads and valid stays 1.
- Overrun: a word completes while valid=1 and ready=0. The new word is discarded, the held word is unchanged, and overrun=1 for exactly one clk.
- Framing-error words are still delivered, with frame_err=1. A break appears as data=0 and frame_err=1.
- busy: 1 from the START entry clk until the clk the FSM returns to IDLE, including WAIT_IDLE.
- Busy line: back-to-back frames with no idle gap are supported. A new falling edge is accepted in IDLE directly after STOP.

Test Plan:
- Bench clocking: CLK_=1600000, BAUD_=100000, OVERSAMPLE_=16 (divider 1, 16 clk per bit).
- 8N1 basic: send 0xA5, ready=1 -> one valid cycle with data=0xA5 and both error flags 0. valid rises 1 clk after the middle of the stop bit (start edge + 9*16+9+2 sync clks, ±1).
- Parity, PARITY="even": send 0x37 with parity bit 1 -> parity_err=0. Send 0x37 with parity bit 0 -> data=0x37, parity_err=1.
- Glitch: rx low for 4 clk, then high -> no valid, busy pulses then returns 0 within 9 clk.
- Break: rx low for 20 bit times, then high for 2 bits, then send 0x55 -> exactly one word data=0x00 with frame_err=1, then data=0x55 with frame_err=0.
- Overrun: ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11 and overrun pulses once. Then ready=1 for 1 clk -> valid drops to 0.
- Reset mid-frame: drop rst_ during data bit 3 of 0xFF -> outputs at reset values immediately. Release, then send 0x3C -> exactly one word, 0x3C, no errors.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART serial receiver: 2-flop rx synchroniser, oversampled majority-vote bit decisions, parity/stop checks.
// Latency: the word is presented one clk after the decision tick of the last stop bit.
// Backpressure: a one-word holding register with valid/ready; a word completing while it is full is dropped and flagged on overrun.
module uart_rx #(
  parameter int    CLK_        = 50000000,
  parameter int    BAUD_       = 115200,
  parameter int    DATA_       = 8,
  parameter int    STOP_       = 1,
  parameter string PARITY      = "none",
  parameter int    OVERSAMPLE_ = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             rx,
  output logic [DATA_-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  // Divider rounded to the nearest integer, never below one clk per tick.
  localparam int DIV_RAW = (CLK_ + (BAUD_ * OVERSAMPLE_) / 2) / (BAUD_ * OVERSAMPLE_);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE_);
  localparam int BW      = $clog2(DATA_ + 1);
  localparam int M       = OVERSAMPLE_ / 2;

  localparam bit PAR_EN   = (PARITY != "none");
  localparam bit PAR_EVEN = (PARITY == "even");
  localparam bit PAR_ODD  = (PARITY == "odd");
  localparam bit PAR_MARK = (PARITY == "mark");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rxs_q;
  logic [DW-1:0]    r_div;
  logic [SW-1:0]    r_sc;
  logic [BW-1:0]    r_bcnt;
  logic [DATA_-1:0] r_shift;
  logic             r_s0;
  logic             r_s1;
  logic             r_perr;
  logic             r_ferr;

  logic [DATA_-1:0] r_data;
  logic             r_valid;
  logic             r_perr_o;
  logic             r_ferr_o;
  logic             r_ovr;

  logic             w_rxs;
  logic             w_fall;
  logic             w_tick;
  logic             w_decide;
  logic             w_wrap;
  logic             w_bit;
  logic             w_par_exp;

  logic             w_frame_start;
  logic             w_shift_en;
  logic             w_bcnt_clr;
  logic             w_bcnt_inc;
  logic             w_perr_set;
  logic             w_ferr_set;
  logic             w_done;

  assign w_rxs    = r_sync2;
  assign w_fall   = r_rxs_q & ~w_rxs;
  assign w_tick   = (r_div == DW'(DIV - 1));
  assign w_decide = w_tick && (r_sc == SW'(M + 1));
  assign w_wrap   = w_tick && (r_sc == SW'(OVERSAMPLE_ - 1));
  // Two of the three samples around mid-bit carry the decision; the third is the live value.
  assign w_bit    = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  // Bring the asynchronous line into the clk domain and keep last value for edge detection.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_q <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rxs_q <= r_sync2;
    end
  end

  // Free-running oversample divider, re-phased on the start edge so ticks line up with the frame.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_div <= '0;
    end else if (w_frame_start || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Tick position within the current bit; held at zero while idle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sc <= '0;
    end else if (r_state == S_IDLE) begin
      r_sc <= '0;
    end else if (w_tick) begin
      r_sc <= (r_sc == SW'(OVERSAMPLE_ - 1)) ? '0 : r_sc + 1'b1;
    end
  end

  // Capture the two early majority samples just before and at mid-bit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else if (w_tick) begin
      if (r_sc == SW'(M - 1)) r_s0 <= w_rxs;
      if (r_sc == SW'(M))     r_s1 <= w_rxs;
    end
  end

  // Expected parity bit for the word currently in the shift register.
  always_comb begin
    w_par_exp = 1'b0;
    if (PAR_EVEN)      w_par_exp = ^r_shift;
    else if (PAR_ODD)  w_par_exp = ~^r_shift;
    else if (PAR_MARK) w_par_exp = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_bcnt_clr    = 1'b0;
    w_bcnt_inc    = 1'b0;
    w_perr_set    = 1'b0;
    w_ferr_set    = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = S_START;
          w_frame_start = 1'b1;
        end
      end
      S_START: begin
        // A start bit that reads high at mid-bit was a glitch, not a frame.
        if (w_decide && w_bit) begin
          w_state_nxt = S_IDLE;
        end else if (w_wrap) begin
          w_state_nxt = S_DATA;
          w_bcnt_clr  = 1'b1;
        end
      end
      S_DATA: begin
        if (w_decide) w_shift_en = 1'b1;
        if (w_wrap) begin
          if (r_bcnt == BW'(DATA_ - 1)) begin
            w_bcnt_clr  = 1'b1;
            w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            w_bcnt_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_decide && (w_bit != w_par_exp)) w_perr_set = 1'b1;
        if (w_wrap) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_decide) begin
          if (!w_bit) w_ferr_set = 1'b1;
          // The word completes mid-way through the last stop bit so a following start edge is not missed.
          if (r_bcnt == BW'(STOP_ - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = (r_ferr || !w_bit) ? S_WAIT_IDLE : S_IDLE;
          end
        end
        if (w_wrap) w_bcnt_inc = 1'b1;
      end
      S_WAIT_IDLE: begin
        // A held break must release before another frame can start.
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit counter for data and stop bits.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_bcnt <= '0;
    end else if (w_frame_start || w_bcnt_clr) begin
      r_bcnt <= '0;
    end else if (w_bcnt_inc) begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // LSB-first shift register: the first data bit ends up in bit 0.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_bit, r_shift[DATA_-1:1]};
    end
  end

  // Per-frame error accumulators, cleared at each start edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (w_frame_start) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_perr_set) r_perr <= 1'b1;
      if (w_ferr_set) r_ferr <= 1'b1;
    end
  end

  // Output holding register: load when empty or draining this cycle, else drop and flag overrun.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || ready)) begin
        r_data   <= r_shift;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | w_ferr_set;
        r_valid  <= 1'b1;
      end else begin
        if (w_done) r_ovr <= 1'b1;
        if (r_valid && ready) r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: one 8N1 receiver and one 8E1 receiver driven by bit-level frame generators.
// Expected words come from a frame-level model (data, parity by ones-count, stop bit level).
// Words are collected on valid && ready at the falling clock edge.
module tb_uart_rx;

  localparam int BITCLK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rx_v;
  logic [1:0] rdy;

  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, pe_n, pe_e, fe_n, fe_e, ovr_n, ovr_e, busy_n, busy_e;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  word_t got0[$];
  word_t got1[$];
  int    ovr_cnt_n = 0;
  int    ovr_cnt_e = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLK_(1600000), .BAUD_(100000), .DATA_(8), .STOP_(1), .PARITY("none"), .OVERSAMPLE_(16)) u_dut_n (
    .clk(clk), .rst_(rst_n), .rx(rx_v[0]), .data(data_n), .valid(valid_n), .ready(rdy[0]),
    .parity_err(pe_n), .frame_err(fe_n), .overrun(ovr_n), .busy(busy_n)
  );

  uart_rx #(.CLK_(1600000), .BAUD_(100000), .DATA_(8), .STOP_(1), .PARITY("even"), .OVERSAMPLE_(16)) u_dut_e (
    .clk(clk), .rst_(rst_n), .rx(rx_v[1]), .data(data_e), .valid(valid_e), .ready(rdy[1]),
    .parity_err(pe_e), .frame_err(fe_e), .overrun(ovr_e), .busy(busy_e)
  );

  always @(negedge clk) begin
    if (valid_n && rdy[0]) got0.push_back({data_n, pe_n, fe_n});
    if (valid_e && rdy[1]) got1.push_back({data_e, pe_e, fe_e});
    if (ovr_n) ovr_cnt_n++;
    if (ovr_e) ovr_cnt_e++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit w, input logic b);
    rx_v[w] = b;
  endtask

  // A frame is start(0), data LSB first, optional parity bit, one stop bit; line left idle.
  task automatic send_frame(input bit w, input logic [7:0] d, input bit has_par, input logic pbit, input logic stopb);
    set_rx(w, 1'b0);
    clks(BITCLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, d[i]);
      clks(BITCLK);
    end
    if (has_par) begin
      set_rx(w, pbit);
      clks(BITCLK);
    end
    set_rx(w, stopb);
    clks(BITCLK);
    set_rx(w, 1'b1);
  endtask

  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic word_t model(input logic [7:0] d, input bit has_par, input logic pbit, input logic stopb);
    word_t m;
    m.d  = d;
    m.pe = has_par && (($countones({d, pbit}) % 2) != 0);
    m.fe = (stopb == 1'b0);
    return m;
  endfunction

  task automatic expect_word(input bit w, input word_t exp, input string tag);
    word_t g;
    bit    have;
    for (int n = 0; n < 600; n++) begin
      if ((w ? got1.size() : got0.size()) != 0) break;
      clks(1);
    end
    have = ((w ? got1.size() : got0.size()) != 0);
    check({tag, ":arrived"}, 32'(have), 32'd1);
    if (have) begin
      if (w) g = got1.pop_front();
      else   g = got0.pop_front();
      check({tag, ":data"}, 32'(g.d), 32'(exp.d));
      check({tag, ":parity_err"}, 32'(g.pe), 32'(exp.pe));
      check({tag, ":frame_err"}, 32'(g.fe), 32'(exp.fe));
    end
  endtask

  initial begin
    int          lat;
    int          n;
    int          base;
    bit          saw;
    logic [7:0]  d;
    logic        pbit;
    logic        stopb;

    rst_n = 1'b0;
    rx_v  = 2'b11;
    rdy   = 2'b11;
    clks(3);

    check("rst_valid_n", 32'(valid_n), 32'd0);
    check("rst_data_n", 32'(data_n), 32'd0);
    check("rst_perr_n", 32'(pe_n), 32'd0);
    check("rst_ferr_n", 32'(fe_n), 32'd0);
    check("rst_ovr_n", 32'(ovr_n), 32'd0);
    check("rst_busy_n", 32'(busy_n), 32'd0);
    check("rst_valid_e", 32'(valid_e), 32'd0);
    check("rst_data_e", 32'(data_e), 32'd0);
    check("rst_busy_e", 32'(busy_e), 32'd0);

    rst_n = 1'b1;
    clks(5);

    // 8N1 basic word and its latency from the start edge: nominal 9*16+9+2, plus START entry and output register.
    lat = 0;
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        while (!valid_n && lat < 400) begin
          clks(1);
          lat++;
        end
      end
    join
    check("basic_latency_in_window", 32'(lat >= 154 && lat <= 158), 32'd1);
    expect_word(1'b0, model(8'hA5, 1'b0, 1'b0, 1'b1), "basic");
    clks(2 * BITCLK);
    check("basic_single_word", 32'(got0.size()), 32'd0);

    // Even parity: correct and wrong parity bit on the same byte.
    send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1);
    clks(BITCLK);
    expect_word(1'b1, model(8'h37, 1'b1, 1'b1, 1'b1), "par_good");
    send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1);
    clks(BITCLK);
    expect_word(1'b1, model(8'h37, 1'b1, 1'b0, 1'b1), "par_bad");

    // Start-bit glitch: short low pulse is rejected.
    set_rx(1'b0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clks(1);
      if (busy_n) saw = 1'b1;
    end
    check("glitch_busy_rise", 32'(saw), 32'd1);
    set_rx(1'b0, 1'b1);
    n = 0;
    while (busy_n && n < 20) begin
      clks(1);
      n++;
    end
    check("glitch_busy_fall_within_9", 32'(!busy_n && n <= 9), 32'd1);
    clks(3 * BITCLK);
    check("glitch_no_word", 32'(got0.size()), 32'd0);

    // Held break yields exactly one zero word with frame_err, then normal reception resumes.
    set_rx(1'b0, 1'b0);
    clks(20 * BITCLK);
    set_rx(1'b0, 1'b1);
    clks(2 * BITCLK);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    clks(BITCLK);
    expect_word(1'b0, model(8'h00, 1'b0, 1'b0, 1'b0), "break");
    expect_word(1'b0, model(8'h55, 1'b0, 1'b0, 1'b1), "after_break");
    check("break_word_count", 32'(got0.size()), 32'd0);

    // Overrun: two back-to-back words with the consumer stalled.
    rdy[0] = 1'b0;
    base = ovr_cnt_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    clks(2 * BITCLK);
    check("ovr_valid_held", 32'(valid_n), 32'd1);
    check("ovr_data_held", 32'(data_n), 32'h11);
    check("ovr_pulse_count", 32'(ovr_cnt_n - base), 32'd1);
    rdy[0] = 1'b1;
    clks(1);
    rdy[0] = 1'b0;
    check("ovr_valid_drop", 32'(valid_n), 32'd0);
    expect_word(1'b0, model(8'h11, 1'b0, 1'b0, 1'b1), "ovr_word");
    rdy[0] = 1'b1;

    // Reset during data bit 3 of 0xFF abandons the frame.
    set_rx(1'b0, 1'b0);
    clks(BITCLK);
    set_rx(1'b0, 1'b1);
    clks(3 * BITCLK + 8);
    check("midrst_busy_before", 32'(busy_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_n), 32'd0);
    check("midrst_valid", 32'(valid_n), 32'd0);
    check("midrst_data", 32'(data_n), 32'd0);
    check("midrst_flags", 32'({pe_n, fe_n, ovr_n}), 32'd0);
    clks(4);
    rst_n = 1'b1;
    clks(6 * BITCLK);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    clks(BITCLK);
    expect_word(1'b0, model(8'h3C, 1'b0, 1'b0, 1'b1), "post_rst");
    check("post_rst_word_count", 32'(got0.size()), 32'd0);

    // Random frames on the parity receiver: random data, parity right or wrong, occasional bad stop bit.
    for (int i = 0; i < 10; i++) begin
      d     = 8'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stopb = ($urandom_range(0, 3) != 0);
      send_frame(1'b1, d, 1'b1, pbit, stopb);
      expect_word(1'b1, model(d, 1'b1, pbit, stopb), "rand_e");
      if (!stopb) clks(2 * BITCLK);
      else        clks(BITCLK * $urandom_range(0, 1));
    end

    // Random back-to-back or gapped frames on the no-parity receiver.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
      expect_word(1'b0, model(d, 1'b0, 1'b0, 1'b1), "rand_n");
      clks(BITCLK * $urandom_range(0, 1));
    end

    clks(2 * BITCLK);
    check("end_no_stray_n", 32'(got0.size()), 32'd0);
    check("end_no_stray_e", 32'(got1.size()), 32'd0);
    check("end_no_overrun_e", 32'(ovr_cnt_e), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
